// File: rtl/alu_issue_sched.sv
// Issue scheduler between the reservation station and the single-cycle ALU.
// Define AGE_PRIORITY_EN to make selection oldest-ready-first instead of lowest-index-first.
module alu_issue_sched #(
  parameter int ROB_WIDTH = 4,
  parameter int RS_WIDTH  = 3,
  parameter int RS_DEPTH  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 in_valid,
  input  logic [3:0]           in_opcode,
  input  logic [31:0]          in_lhs_val,
  input  logic [31:0]          in_rhs_val,
  input  logic                 in_lhs_rdy,
  input  logic                 in_rhs_rdy,
  input  logic [ROB_WIDTH-1:0] in_lhs_tag,
  input  logic [ROB_WIDTH-1:0] in_rhs_tag,
  input  logic [ROB_WIDTH-1:0] in_tag,
  output logic                 in_full,
  input  logic                 alu_done,
  input  logic [31:0]          alu_value,
  input  logic [ROB_WIDTH-1:0] alu_tag,
  input  logic                 lsb_done,
  input  logic [31:0]          lsb_value,
  input  logic [ROB_WIDTH-1:0] lsb_tag,
  output logic                 cal_signal,
  output logic [3:0]           opcode,
  output logic [31:0]          lhs,
  output logic [31:0]          rhs,
  output logic [ROB_WIDTH-1:0] tag
);

  typedef struct packed {
    logic        rdy;
    logic [31:0] val;
  } opnd_t;

  // ALU broadcast is checked first so it wins when both buses carry the tag.
  function automatic opnd_t snoop(input logic rdy, input logic [31:0] val,
                                  input logic [ROB_WIDTH-1:0] tg,
                                  input logic a_done, input logic [ROB_WIDTH-1:0] a_tag,
                                  input logic [31:0] a_val,
                                  input logic l_done, input logic [ROB_WIDTH-1:0] l_tag,
                                  input logic [31:0] l_val);
    opnd_t o;
    if (rdy) begin
      o = {1'b1, val};
    end else if (a_done && (a_tag == tg)) begin
      o = {1'b1, a_val};
    end else if (l_done && (l_tag == tg)) begin
      o = {1'b1, l_val};
    end else begin
      o = {1'b0, val};
    end
    return o;
  endfunction

  logic [RS_DEPTH-1:0]  valid_r;
  logic [RS_DEPTH-1:0]  lrdy_r;
  logic [RS_DEPTH-1:0]  rrdy_r;
  logic [3:0]           opcode_r [RS_DEPTH];
  logic [ROB_WIDTH-1:0] dtag_r   [RS_DEPTH];
  logic [31:0]          lval_r   [RS_DEPTH];
  logic [31:0]          rval_r   [RS_DEPTH];
  logic [ROB_WIDTH-1:0] ltag_r   [RS_DEPTH];
  logic [ROB_WIDTH-1:0] rtag_r   [RS_DEPTH];
`ifdef AGE_PRIORITY_EN
  localparam logic [RS_WIDTH-1:0] AGE_MAX = RS_WIDTH'(RS_DEPTH - 1);
  logic [RS_WIDTH-1:0]  age_r    [RS_DEPTH];
  logic [RS_WIDTH-1:0]  sel_age_s;
`endif

  logic [RS_WIDTH:0]    count_s;
  logic                 free_found_s;
  logic [RS_WIDTH-1:0]  free_idx_s;
  logic                 sel_found_s;
  logic [RS_WIDTH-1:0]  sel_idx_s;
  logic                 enq_s;
  opnd_t                lwk_s [RS_DEPTH];
  opnd_t                rwk_s [RS_DEPTH];
  opnd_t                enq_l_s;
  opnd_t                enq_r_s;

  // Occupancy, free-slot search, ready selection and operand snooping from registered state.
  always_comb begin
    count_s      = '0;
    free_found_s = 1'b0;
    free_idx_s   = '0;
    sel_found_s  = 1'b0;
    sel_idx_s    = '0;
`ifdef AGE_PRIORITY_EN
    sel_age_s    = '0;
`endif
    for (int i = 0; i < RS_DEPTH; i++) begin
      count_s = count_s + (RS_WIDTH + 1)'(valid_r[i]);
      if (!valid_r[i] && !free_found_s) begin
        free_found_s = 1'b1;
        free_idx_s   = RS_WIDTH'(i);
      end
`ifdef AGE_PRIORITY_EN
      if (valid_r[i] && lrdy_r[i] && rrdy_r[i] && (!sel_found_s || (age_r[i] > sel_age_s))) begin
        sel_found_s = 1'b1;
        sel_idx_s   = RS_WIDTH'(i);
        sel_age_s   = age_r[i];
      end
`else
      if (valid_r[i] && lrdy_r[i] && rrdy_r[i] && !sel_found_s) begin
        sel_found_s = 1'b1;
        sel_idx_s   = RS_WIDTH'(i);
      end
`endif
      lwk_s[i] = snoop(lrdy_r[i], lval_r[i], ltag_r[i], alu_done, alu_tag, alu_value,
                       lsb_done, lsb_tag, lsb_value);
      rwk_s[i] = snoop(rrdy_r[i], rval_r[i], rtag_r[i], alu_done, alu_tag, alu_value,
                       lsb_done, lsb_tag, lsb_value);
    end
    enq_l_s = snoop(in_lhs_rdy, in_lhs_val, in_lhs_tag, alu_done, alu_tag, alu_value,
                    lsb_done, lsb_tag, lsb_value);
    enq_r_s = snoop(in_rhs_rdy, in_rhs_val, in_rhs_tag, alu_done, alu_tag, alu_value,
                    lsb_done, lsb_tag, lsb_value);
    in_full = (count_s == (RS_WIDTH + 1)'(RS_DEPTH));
    enq_s   = in_valid && !in_full && !clear_signal && free_found_s;
  end

  // Entry storage, wakeup, enqueue and registered issue outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_r    <= '0;
      lrdy_r     <= '0;
      rrdy_r     <= '0;
      cal_signal <= 1'b0;
      opcode     <= 4'd0;
      lhs        <= 32'd0;
      rhs        <= 32'd0;
      tag        <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        opcode_r[i] <= 4'd0;
        dtag_r[i]   <= '0;
        lval_r[i]   <= 32'd0;
        rval_r[i]   <= 32'd0;
        ltag_r[i]   <= '0;
        rtag_r[i]   <= '0;
`ifdef AGE_PRIORITY_EN
        age_r[i]    <= '0;
`endif
      end
    end else if (rdy_in) begin
      if (clear_signal) begin
        valid_r    <= '0;
        cal_signal <= 1'b0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (valid_r[i]) begin
            lrdy_r[i] <= lwk_s[i].rdy;
            lval_r[i] <= lwk_s[i].val;
            rrdy_r[i] <= rwk_s[i].rdy;
            rval_r[i] <= rwk_s[i].val;
`ifdef AGE_PRIORITY_EN
            if (enq_s && (age_r[i] != AGE_MAX)) begin
              age_r[i] <= age_r[i] + 1'b1;
            end
`endif
          end
        end
        if (sel_found_s) begin
          cal_signal          <= 1'b1;
          opcode              <= opcode_r[sel_idx_s];
          lhs                 <= lval_r[sel_idx_s];
          rhs                 <= rval_r[sel_idx_s];
          tag                 <= dtag_r[sel_idx_s];
          valid_r[sel_idx_s]  <= 1'b0;
        end else begin
          cal_signal <= 1'b0;
        end
        // The free slot is invalid pre-edge, so it never collides with the issued slot.
        if (enq_s) begin
          valid_r[free_idx_s]  <= 1'b1;
          opcode_r[free_idx_s] <= in_opcode;
          dtag_r[free_idx_s]   <= in_tag;
          lrdy_r[free_idx_s]   <= enq_l_s.rdy;
          lval_r[free_idx_s]   <= enq_l_s.val;
          ltag_r[free_idx_s]   <= in_lhs_tag;
          rrdy_r[free_idx_s]   <= enq_r_s.rdy;
          rval_r[free_idx_s]   <= enq_r_s.val;
          rtag_r[free_idx_s]   <= in_rhs_tag;
`ifdef AGE_PRIORITY_EN
          age_r[free_idx_s]    <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed self-checking bench for alu_issue_sched; expectations are hand-computed.
module tb_alu_issue_sched;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear_signal;
  logic        in_valid;
  logic [3:0]  in_opcode;
  logic [31:0] in_lhs_val;
  logic [31:0] in_rhs_val;
  logic        in_lhs_rdy;
  logic        in_rhs_rdy;
  logic [3:0]  in_lhs_tag;
  logic [3:0]  in_rhs_tag;
  logic [3:0]  in_tag;
  logic        in_full;
  logic        alu_done;
  logic [31:0] alu_value;
  logic [3:0]  alu_tag;
  logic        lsb_done;
  logic [31:0] lsb_value;
  logic [3:0]  lsb_tag;
  logic        cal_signal;
  logic [3:0]  opcode;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [3:0]  tag;

  int errors = 0;
  int checks = 0;

  alu_issue_sched #(.ROB_WIDTH(4), .RS_WIDTH(3), .RS_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .in_valid(in_valid), .in_opcode(in_opcode), .in_lhs_val(in_lhs_val),
    .in_rhs_val(in_rhs_val), .in_lhs_rdy(in_lhs_rdy), .in_rhs_rdy(in_rhs_rdy),
    .in_lhs_tag(in_lhs_tag), .in_rhs_tag(in_rhs_tag), .in_tag(in_tag), .in_full(in_full),
    .alu_done(alu_done), .alu_value(alu_value), .alu_tag(alu_tag),
    .lsb_done(lsb_done), .lsb_value(lsb_value), .lsb_tag(lsb_tag),
    .cal_signal(cal_signal), .opcode(opcode), .lhs(lhs), .rhs(rhs), .tag(tag)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    clear_signal = 1'b0;
    alu_done     = 1'b0;
    lsb_done     = 1'b0;
  endtask

  task automatic enq(input logic [3:0] op, input logic lr, input logic [31:0] lv,
                     input logic [3:0] lt, input logic rr, input logic [31:0] rv,
                     input logic [3:0] rt, input logic [3:0] dt);
    in_valid   = 1'b1;
    in_opcode  = op;
    in_lhs_rdy = lr;
    in_lhs_val = lv;
    in_lhs_tag = lt;
    in_rhs_rdy = rr;
    in_rhs_val = rv;
    in_rhs_tag = rt;
    in_tag     = dt;
  endtask

  initial begin
    rst_n_in  = 1'b0;
    rdy_in    = 1'b1;
    idle();
    enq(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    in_valid  = 1'b0;
    alu_value = 32'd0;
    alu_tag   = 4'd0;
    lsb_value = 32'd0;
    lsb_tag   = 4'd0;
    #3;
    chk("rst_cal", {31'd0, cal_signal}, 32'd0);
    chk("rst_opcode", {28'd0, opcode}, 32'd0);
    chk("rst_lhs", lhs, 32'd0);
    chk("rst_rhs", rhs, 32'd0);
    chk("rst_tag", {28'd0, tag}, 32'd0);
    chk("rst_full", {31'd0, in_full}, 32'd0);
    #9 rst_n_in = 1'b1;

    // ADD with both operands ready: issue one edge after enqueue
    enq(4'd4, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
    tick();
    idle();
    chk("add_not_yet", {31'd0, cal_signal}, 32'd0);
    tick();
    chk("add_cal", {31'd0, cal_signal}, 32'd1);
    chk("add_opcode", {28'd0, opcode}, 32'd4);
    chk("add_lhs", lhs, 32'd5);
    chk("add_rhs", rhs, 32'd7);
    chk("add_tag", {28'd0, tag}, 32'd3);
    tick();
    chk("add_cal_drop", {31'd0, cal_signal}, 32'd0);
    chk("add_tag_hold", {28'd0, tag}, 32'd3);

    // SUB with rhs pending on tag 6, woken by the ALU a cycle later
    enq(4'd1, 1'b1, 32'd20, 4'd0, 1'b0, 32'd0, 4'd6, 4'd2);
    tick();
    idle();
    tick();
    chk("sub_wait", {31'd0, cal_signal}, 32'd0);
    alu_done  = 1'b1;
    alu_tag   = 4'd6;
    alu_value = 32'h10;
    tick();
    idle();
    chk("sub_capture_no_fwd", {31'd0, cal_signal}, 32'd0);
    tick();
    chk("sub_cal", {31'd0, cal_signal}, 32'd1);
    chk("sub_opcode", {28'd0, opcode}, 32'd1);
    chk("sub_lhs", lhs, 32'd20);
    chk("sub_rhs", rhs, 32'h10);
    chk("sub_tag", {28'd0, tag}, 32'd2);
    tick();

    // Fill all 8 slots waiting on tag 1, refuse a ninth, then drain in order
    for (int i = 0; i < 8; i++) begin
      enq(4'd3, 1'b0, 32'd0, 4'd1, 1'b1, 32'(i), 4'd0, 4'(i));
      tick();
    end
    chk("fill_full", {31'd0, in_full}, 32'd1);
    chk("fill_no_issue", {31'd0, cal_signal}, 32'd0);
    enq(4'd5, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd9);
    tick();
    chk("ninth_full", {31'd0, in_full}, 32'd1);
    idle();
    lsb_done  = 1'b1;
    lsb_tag   = 4'd1;
    lsb_value = 32'h55;
    tick();
    idle();
    chk("drain_wake_no_issue", {31'd0, cal_signal}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_cal", {31'd0, cal_signal}, 32'd1);
      chk("drain_tag", {28'd0, tag}, 32'(i));
      chk("drain_lhs", lhs, 32'h55);
    end
    chk("drain_full_clear", {31'd0, in_full}, 32'd0);
    tick();
    chk("ninth_refused", {31'd0, cal_signal}, 32'd0);

    // Broadcast coinciding with enqueue is captured
    enq(4'd2, 1'b0, 32'd0, 4'd2, 1'b1, 32'd3, 4'd0, 4'd5);
    lsb_done  = 1'b1;
    lsb_tag   = 4'd2;
    lsb_value = 32'hAB;
    tick();
    idle();
    tick();
    chk("snoop_cal", {31'd0, cal_signal}, 32'd1);
    chk("snoop_lhs", lhs, 32'hAB);
    chk("snoop_rhs", rhs, 32'd3);
    chk("snoop_tag", {28'd0, tag}, 32'd5);
    tick();
    chk("snoop_drop", {31'd0, cal_signal}, 32'd0);

    // Flush overrides issue of ready entries
    for (int i = 0; i < 3; i++) begin
      enq(4'd6, 1'b0, 32'd0, 4'd7, 1'b1, 32'd0, 4'd0, 4'(10 + i));
      tick();
    end
    idle();
    alu_done  = 1'b1;
    alu_tag   = 4'd7;
    alu_value = 32'h77;
    tick();
    idle();
    clear_signal = 1'b1;
    tick();
    idle();
    chk("flush_cal", {31'd0, cal_signal}, 32'd0);
    chk("flush_full", {31'd0, in_full}, 32'd0);
    tick();
    tick();
    chk("flush_no_issue", {31'd0, cal_signal}, 32'd0);

    // rdy_in low freezes outputs and ignores enqueue/clear/broadcast
    enq(4'd7, 1'b0, 32'd0, 4'd8, 1'b1, 32'd1, 4'd0, 4'd14);
    tick();
    enq(4'd8, 1'b0, 32'd0, 4'd8, 1'b1, 32'd2, 4'd0, 4'd15);
    tick();
    idle();
    lsb_done  = 1'b1;
    lsb_tag   = 4'd8;
    lsb_value = 32'h88;
    tick();
    idle();
    tick();
    chk("hold_pre_tag", {28'd0, tag}, 32'd14);
    rdy_in       = 1'b0;
    clear_signal = 1'b1;
    enq(4'd9, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0, 4'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_cal", {31'd0, cal_signal}, 32'd1);
      chk("hold_tag", {28'd0, tag}, 32'd14);
      chk("hold_rhs", rhs, 32'd1);
    end
    rdy_in = 1'b1;
    idle();
    tick();
    chk("resume_tag", {28'd0, tag}, 32'd15);
    chk("resume_lhs", lhs, 32'h88);
    tick();
    chk("resume_empty", {31'd0, cal_signal}, 32'd0);

    // Priority: slot 5 enqueued before slot 0, both woken on one edge
    for (int i = 0; i < 6; i++) begin
      enq(4'd1, 1'b0, 32'd0, (i == 5) ? 4'd2 : 4'd1, 1'b1, 32'd0, 4'd0,
          (i == 5) ? 4'd13 : 4'(i));
      tick();
    end
    idle();
    lsb_done  = 1'b1;
    lsb_tag   = 4'd1;
    lsb_value = 32'd1;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("prio_drain_tag", {28'd0, tag}, 32'(i));
    end
    enq(4'd1, 1'b0, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0, 4'd14);
    tick();
    idle();
    alu_done  = 1'b1;
    alu_tag   = 4'd2;
    alu_value = 32'h22;
    tick();
    idle();
    chk("prio_wake_no_issue", {31'd0, cal_signal}, 32'd0);
    tick();
    chk("prio_first_cal", {31'd0, cal_signal}, 32'd1);
`ifdef AGE_PRIORITY_EN
    chk("prio_first_tag", {28'd0, tag}, 32'd13);
    tick();
    chk("prio_second_tag", {28'd0, tag}, 32'd14);
`else
    chk("prio_first_tag", {28'd0, tag}, 32'd14);
    tick();
    chk("prio_second_tag", {28'd0, tag}, 32'd13);
`endif
    tick();
    chk("prio_end", {31'd0, cal_signal}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
- Issue scheduler between the reservation station and the single-cycle ALU.
- Buffers up to RS_DEPTH decoded ALU ops whose operands may still be pending.
- Captures pending operands from the ALU and LSB result broadcasts (wakeup).
- Issues one ready op per cycle to the ALU; flushes everything on mispredict.

Parameters:
- ROB_WIDTH, 4, width of ROB tags for destination and operand dependencies.
- RS_WIDTH, 3, log2 of queue depth.
- RS_DEPTH, 8, number of entries; must equal 2**RS_WIDTH.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  global ready; low pauses the block.
- clear_signal  in  1  mispredict flush.
- in_valid  in  1  enqueue request from RS.
- in_opcode  in  4  ALU opcode, same 4-bit encoding the ALU uses.
- in_lhs_val / in_rhs_val  in  32  operand values, meaningful when the matching rdy is 1.
- in_lhs_rdy / in_rhs_rdy  in  1  operand already available.
- in_lhs_tag / in_rhs_tag  in  ROB_WIDTH  producer tag when the operand is not ready.
- in_tag  in  ROB_WIDTH  destination ROB tag.
- in_full  out  1  queue full; enqueue is refused.
- alu_done / alu_value / alu_tag  in  1/32/ROB_WIDTH  ALU result broadcast.
- lsb_done / lsb_value / lsb_tag  in  1/32/ROB_WIDTH  LSB result broadcast.
- cal_signal  out  1  issue strobe to the ALU.
- opcode  out  4  issued opcode.
- lhs / rhs  out  32  issued operands.
- tag  out  ROB_WIDTH  issued destination tag.

Behaviour:
- Reset (rst_n_in=0, async): all entry valid bits 0, cal_signal=0, opcode=0, lhs=0, rhs=0, tag=0, in_full=0.
- Per entry: valid, opcode, dest tag, and for each operand {rdy, val, tag}. An entry is "ready" when valid and both operand rdy bits are 1.
- in_full = count of valid entries == RS_DEPTH. It is combinational from registered state only.
- Enqueue when rdy_in & in_valid & !in_full & !clear_signal. The entry goes into the lowest-index free slot, computed from pre-edge state.
  - A slot freed by an issue in the same cycle is not reusable until the next cycle.
  - When full and issuing in the same cycle, the enqueue is refused.
- Wakeup on each rdy_in edge: for every valid entry and every non-ready operand, a match with alu_done&alu_tag or lsb_done&lsb_tag sets rdy=1 and captures the value.
  - If both broadcasts match, ALU wins.
  - An entry enqueued in the same cycle also snoops, so a broadcast coinciding with enqueue is never lost.
- Selection is combinational from registered state; at most one ready entry is picked per cycle (priority below).
- Issue, on the rdy_in edge when a ready entry exists:
  - cal_signal<=1; opcode, lhs, rhs, tag are loaded from that entry; the entry's valid<=0.
  - When no entry is ready: cal_signal<=0 and the data outputs hold.
- Latency:
  - Enqueue with both operands ready at edge N: issue strobe visible after edge N+1 at the earliest.
  - Operand woken at edge N: issue after edge N+1 at the earliest.
  - Throughput: 1 op per cycle.
- Newly-woken operand values are never forwarded combinationally into issue. Issue uses the stored value, one cycle after capture.
- Flush, rdy_in & clear_signal at an edge:
  - All valid bits cleared; cal_signal<=0.
  - Enqueue and wakeup are ignored that edge.
  - Flush overrides issue.
- rdy_in=0: all state and outputs hold. Enqueue, broadcasts and clear are ignored.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Optional Feature:
- Macro AGE_PRIORITY_EN.
- Defined:
  - Each entry carries an RS_WIDTH-bit age. It is set to 0 on enqueue, and every other valid entry's age increments, saturating at RS_DEPTH-1.
  - Selection picks the ready entry with the largest age; ties go to the lowest index.
- Undefined:
  - No age state.
  - Selection picks the lowest-index ready entry.

Test Plan:
- Reset then enqueue ADD (opcode 4), lhs=5 rdy, rhs=7 rdy, tag=3 -> next edge: cal_signal=1, opcode=4, lhs=5, rhs=7, tag=3; following edge: cal_signal=0.
- Enqueue SUB with rhs pending tag=6. A cycle later, alu_done=1, alu_tag=6, alu_value=0x10 -> entry captures 0x10; issues one edge after capture with rhs=0x10.
- Enqueue 8 entries whose operands all wait on tag 1 -> in_full=1 and the 9th in_valid is refused. Broadcast tag 1 via lsb -> 8 consecutive issue cycles, then in_full=0.
- Same-cycle enqueue with pending lhs tag=2 while lsb_done=1, lsb_tag=2, lsb_value=0xAB -> entry stored ready with lhs=0xAB; issues next edge.
- Three waiting entries, then clear_signal=1 while a ready entry exists -> cal_signal=0 after the edge, in_full=0, no later issue. Hold rdy_in=0 for 3 cycles with ready entries present -> outputs frozen.
- With AGE_PRIORITY_EN: entry in slot 5 enqueued before slot 0, both woken on the same edge -> slot 5 issues first. Without the macro -> slot 0 issues first.
